uart_tx_flow: RTL and testbench

UART transmitter with hardware CTS flow control. It serialises bytes from an internal valid/ready stream onto uart_tx, with a runtime-programmable baud divisor. It is the transmit end of the UART link and sits between the bridge response path and the FPGA TX pin. It holds off new frames while the host deasserts CTS, and produces tx_busy, frame_start and byte_transmitted status for the monitor.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_flow_sync_ff.sv | 24 ++
 rtl/uart_tx_flow.sv | 141 ++++++++++++++
 tb/tb_uart_tx_flow.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int UART_DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Zero-extended data does not change the XOR, so narrower frames reuse this.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_flow_sync_ff.sv
// N-stage flip-flop synchroniser for a single asynchronous input.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_tx_flow.sv
// UART transmitter with CTS flow control and runtime baud divisor.
module uart_tx_flow
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1,
  parameter int CTS_SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [UART_DIV_W-1:0] baud_divisor,
  input  logic                  uart_cts_n,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  frame_start,
  output logic                  byte_transmitted
);

  localparam int               BIT_W     = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  // Divisors 0 and 1 both mean one clock per bit.
  function automatic logic [UART_DIV_W-1:0] sat_div(input logic [UART_DIV_W-1:0] d);
    return (d < UART_DIV_W'(2)) ? UART_DIV_W'(1) : d;
  endfunction

  logic                  cts_sync;
  logic                  cts_ok;
  logic                  accept;
  logic                  shift_en;
  uart_tx_state_t        state;
  uart_tx_state_t        state_nxt;
  logic [UART_DIV_W-1:0] baud_cnt;
  logic [UART_DIV_W-1:0] baud_nxt;
  logic [UART_DIV_W-1:0] div_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_q;
  logic [7:0]            data_ext;

  sync_ff #(
    .STAGES   (CTS_SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_cts_sync (
    .clk(clk),
    .rst(rst),
    .d  (uart_cts_n),
    .q  (cts_sync)
  );

  assign cts_ok   = ~cts_sync;
  assign tx_ready = (state == IDLE) && cts_ok;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state != IDLE);
  assign data_ext = 8'(tx_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      frame_start <= accept;
    end
  end

  // Frame payload is captured once at accept so input changes mid-frame are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= tx_data;
      div_q <= sat_div(baud_divisor);
      par_q <= calc_parity(data_ext, PARITY_ODD != 0);
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  always_comb begin
    state_nxt        = state;
    baud_nxt         = baud_cnt;
    bit_nxt          = bit_cnt;
    shift_en         = 1'b0;
    uart_tx          = 1'b1;
    byte_transmitted = 1'b0;
    if (state != IDLE) begin
      baud_nxt = (baud_cnt == '0) ? div_q - UART_DIV_W'(1) : baud_cnt - UART_DIV_W'(1);
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          baud_nxt  = sat_div(baud_divisor) - UART_DIV_W'(1);
          bit_nxt   = '0;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud_cnt == '0) state_nxt = DATA;
      end
      DATA: begin
        uart_tx = shreg[0];
        if (baud_cnt == '0) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        uart_tx = par_q;
        if (baud_cnt == '0) state_nxt = STOP;
      end
      STOP: begin
        if (baud_cnt == '0) begin
          if (bit_cnt == LAST_STOP) begin
            byte_transmitted = 1'b1;
            state_nxt        = IDLE;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Self-checking bench: 8N1, 8E1 and 8O1 transmitters against a frame-level model.
module tb_uart_tx_flow;

  localparam int CTS_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] baud_divisor;
  logic        uart_cts_n;
  logic [2:0]  ready_v, line_v, busy_v, fs_v, bt_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_tx_flow #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                 .CTS_SYNC_STAGES(CTS_STAGES)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready_v[0]),
    .baud_divisor(baud_divisor), .uart_cts_n(uart_cts_n), .uart_tx(line_v[0]),
    .tx_busy(busy_v[0]), .frame_start(fs_v[0]), .byte_transmitted(bt_v[0]));

  uart_tx_flow #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                 .CTS_SYNC_STAGES(CTS_STAGES)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready_v[1]),
    .baud_divisor(baud_divisor), .uart_cts_n(uart_cts_n), .uart_tx(line_v[1]),
    .tx_busy(busy_v[1]), .frame_start(fs_v[1]), .byte_transmitted(bt_v[1]));

  uart_tx_flow #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1),
                 .CTS_SYNC_STAGES(CTS_STAGES)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready_v[2]),
    .baud_divisor(baud_divisor), .uart_cts_n(uart_cts_n), .uart_tx(line_v[2]),
    .tx_busy(busy_v[2]), .frame_start(fs_v[2]), .byte_transmitted(bt_v[2]));

  // sel 0: no parity, sel 1: even parity, sel 2: odd parity
  function automatic int eff_div(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  function automatic int frame_bits(input int sel);
    return (sel != 0) ? 11 : 10;
  endfunction

  function automatic bit exp_bit(input logic [7:0] d, input int sel, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && sel != 0) return ((($countones(d) + ((sel == 2) ? 1 : 0)) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_all_idle();
    int n = 0;
    @(negedge clk);
    while (busy_v != 3'b000 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy_v), 0);
  endtask

  task automatic transmit(input logic [7:0] d, input logic [15:0] bdiv, input int sel,
                          input int hold, input int cts_cyc, input int mid_div, input int rst_cyc);
    int div, len, waited, lat;
    div = eff_div(int'(bdiv));
    len = frame_bits(sel) * div;
    wait_all_idle();
    if (hold > 0) begin
      uart_cts_n = 1'b1;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    tx_data      = d;
    tx_valid     = 1'b1;
    baud_divisor = bdiv;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_ready", 32'(ready_v[sel]), 0);
        check("hold_line", 32'(line_v[sel]), 1);
      end
      uart_cts_n = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ready_v[sel] && lat < 50);
      check("cts_latency", lat, CTS_STAGES);
    end else begin
      waited = 0;
      @(negedge clk);
      while (!ready_v[sel] && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      check("accept_timeout", 32'(ready_v[sel]), 1);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == rst_cyc) begin
        rst = 1'b0;
        #1;
        check("rst_line", 32'(line_v[sel]), 1);
        check("rst_busy", 32'(busy_v[sel]), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      check("line", 32'(line_v[sel]), 32'(exp_bit(d, sel, c / div)));
      check("busy", 32'(busy_v[sel]), 1);
      check("frame_start", 32'(fs_v[sel]), 32'(c == 0));
      check("byte_tx", 32'(bt_v[sel]), 32'(c == len - 1));
      if (c == cts_cyc) uart_cts_n = 1'b1;
      if (mid_div >= 0 && c == len / 2) baud_divisor = 16'(mid_div);
    end
    @(negedge clk);
    check("gap_line", 32'(line_v[sel]), 1);
    check("gap_busy", 32'(busy_v[sel]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    baud_divisor = 16'd4;
    uart_cts_n   = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_line", 32'(line_v), 32'h7);
    check("reset_ready", 32'(ready_v), 0);
    check("reset_busy", 32'(busy_v), 0);
    check("reset_fs", 32'(fs_v), 0);
    check("reset_bt", 32'(bt_v), 0);
    @(negedge clk);
    rst = 1'b1;

    transmit(8'hA5, 16'd4, 0, 0, -1, -1, -1);
    transmit(8'h3C, 16'd4, 0, 8, -1, -1, -1);
    transmit(8'hFF, 16'd4, 0, 0, 17, -1, -1);
    transmit(8'h00, 16'd4, 0, 6, -1, -1, -1);
    transmit(8'h07, 16'd2, 1, 0, -1, -1, -1);
    transmit(8'h07, 16'd2, 2, 0, -1, -1, -1);
    transmit(8'h5A, 16'd0, 0, 0, -1, -1, -1);
    transmit(8'hC3, 16'd4, 0, 0, -1, 8, -1);
    transmit(8'h3C, 16'd8, 0, 0, -1, -1, -1);

    transmit(8'h96, 16'd4, 0, 0, -1, -1, 14);
    #1;
    check("post_rst_ready", 32'(ready_v), 0);
    check("post_rst_busy", 32'(busy_v), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_line", 32'(line_v), 32'h7);
    end
    transmit(8'h55, 16'd4, 0, 0, -1, -1, -1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0]  d;
      logic [15:0] bd;
      int          sel, hold;
      d    = 8'($urandom);
      bd   = 16'($urandom_range(0, 5));
      sel  = $urandom_range(0, 2);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      transmit(d, bd, sel, hold, -1, -1, -1);
    end

    wait_all_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
